// File: rtl/tiny16_pkg.sv
// Shared definitions for the tiny16 register-file sequencer: opcodes, flag bit positions, FSM states.
package tiny16_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_MOV = 4'h1;
    localparam logic [3:0] OP_LDI = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_NOT = 4'h8;
    localparam logic [3:0] OP_SHL = 4'h9;
    localparam logic [3:0] OP_SHR = 4'hA;
    localparam logic [3:0] OP_CMP = 4'hB;
    localparam logic [3:0] OP_OUT = 4'hC;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_N = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WB
    } state_t;

    function automatic logic is_write(input logic [3:0] op);
        return (op >= OP_MOV) && (op <= OP_SHR);
    endfunction

    function automatic logic updates_flags(input logic [3:0] op);
        return (op >= OP_MOV) && (op <= OP_CMP);
    endfunction

endpackage

// File: rtl/tiny16_alu.sv
// Combinational tiny16 ALU: result and {N,C,Z} from opcode, source S, destination D and immediate.
module tiny16_alu
    import tiny16_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] imm,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       flags
);

    logic [WIDTH:0] wide;
    logic           carry;

    always_comb begin
        wide   = '0;
        carry  = 1'b0;
        result = '0;
        case (op)
            OP_MOV: result = s;
            OP_LDI: result = imm;
            OP_ADD: begin
                wide   = {1'b0, d} + {1'b0, s};
                result = wide[WIDTH-1:0];
                carry  = wide[WIDTH];
            end
            // The extra top bit of an unsigned subtract is the borrow (D < S)
            OP_SUB, OP_CMP: begin
                wide   = {1'b0, d} - {1'b0, s};
                result = wide[WIDTH-1:0];
                carry  = wide[WIDTH];
            end
            OP_AND: result = d & s;
            OP_OR:  result = d | s;
            OP_XOR: result = d ^ s;
            OP_NOT: result = ~s;
            OP_SHL: begin
                result = {s[WIDTH-2:0], 1'b0};
                carry  = s[WIDTH-1];
            end
            OP_SHR: begin
                result = {1'b0, s[WIDTH-1:1]};
                carry  = s[0];
            end
            default: result = '0;
        endcase
        flags         = '0;
        flags[FLAG_N] = result[WIDTH-1];
        flags[FLAG_C] = carry;
        flags[FLAG_Z] = (result == '0);
    end

endmodule

// File: rtl/reg_sequencer.sv
// tiny16 register-file initiator: accepts a decoded instruction, reads operands, executes and writes back.
module reg_sequencer
    import tiny16_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [3:0]       opcode,
    input  logic [SEL_W-1:0] src_sel_i,
    input  logic [SEL_W-1:0] dst_sel_i,
    input  logic [WIDTH-1:0] imm,
    output logic [SEL_W-1:0] src_sel,
    output logic [SEL_W-1:0] dst_sel,
    output logic             in_en,
    output logic [WIDTH-1:0] in,
    output logic             out_en,
    input  logic [WIDTH-1:0] rf_src,
    input  logic [WIDTH-1:0] rf_dst,
    output logic [2:0]       flags,
    output logic             done,
    output logic             illegal
);

    state_t           state_q, state_d;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] imm_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] alu_result;
    logic [2:0]       alu_flags;

    tiny16_alu #(.WIDTH(WIDTH)) u_alu (
        .op     (op_q),
        .s      (rf_src),
        .d      (rf_dst),
        .imm    (imm_q),
        .result (alu_result),
        .flags  (alu_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            imm_q    <= '0;
            src_sel  <= '0;
            dst_sel  <= '0;
            result_q <= '0;
            flags    <= '0;
        end else begin
            if (state_q == ST_IDLE && instr_valid) begin
                op_q    <= opcode;
                imm_q   <= imm;
                src_sel <= src_sel_i;
                dst_sel <= dst_sel_i;
            end
            if (state_q == ST_EXEC) begin
                result_q <= alu_result;
                if (updates_flags(op_q)) begin
                    flags <= alu_flags;
                end
            end
        end
    end

    // Strobes decode from the state register so an async reset clears them at once
    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        in_en       = 1'b0;
        out_en      = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: state_d = ST_EXEC;
            ST_EXEC: state_d = ST_WB;
            ST_WB: begin
                done    = 1'b1;
                in_en   = is_write(op_q);
                out_en  = (op_q == OP_OUT);
                illegal = (op_q > OP_OUT);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in = result_q;

endmodule
